// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: left/right turn sweep and hazard flash across two 3-lamp banks.
// Optional brake overlay is enabled by defining BRAKE_EN.
module tail_light_sequencer #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
`ifdef BRAKE_EN
    input  logic brake,
`endif
    output logic LA,
    output logic LB,
    output logic LC,
    output logic RA,
    output logic RB,
    output logic RC,
    output logic active
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, HON, HOFF
    } state_t;

    state_t         state;
    state_t         state_nxt;
    state_t         start_nxt;
    logic [CW-1:0]  count;
    logic           tick;
    logic           haz_req;
    logic [5:0]     lamp_q;
    logic           active_q;

    // Lamp pattern {LA,LB,LC,RA,RB,RC} for each state.
    function automatic logic [5:0] lamps_of(input state_t s);
        logic [5:0] v;
        v = 6'b000000;
        case (s)
            L1:      v = 6'b100000;
            L2:      v = 6'b110000;
            L3:      v = 6'b111000;
            R1:      v = 6'b000100;
            R2:      v = 6'b000110;
            R3:      v = 6'b000111;
            HON:     v = 6'b111111;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    assign tick    = (count == LAST);
    assign haz_req = hazard | (left & right);

    // Sequence to start from IDLE or at the end of an OFF step.
    always_comb begin
        start_nxt = IDLE;
        if (haz_req)    start_nxt = HON;
        else if (left)  start_nxt = L1;
        else if (right) start_nxt = R1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_nxt;
            L1:      if (tick) state_nxt = haz_req ? HON : L2;
            L2:      if (tick) state_nxt = haz_req ? HON : L3;
            L3:      if (tick) state_nxt = haz_req ? HON : LOFF;
            R1:      if (tick) state_nxt = haz_req ? HON : R2;
            R2:      if (tick) state_nxt = haz_req ? HON : R3;
            R3:      if (tick) state_nxt = haz_req ? HON : ROFF;
            HON:     if (tick) state_nxt = HOFF;
            LOFF,
            ROFF,
            HOFF:    if (tick) state_nxt = start_nxt;
            default: state_nxt = IDLE;
        endcase
    end

    // Lamp register is loaded with the decode of the incoming state, so it tracks the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            lamp_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            lamp_q   <= lamps_of(state_nxt);
            active_q <= (state_nxt != IDLE);
            if (state == IDLE || tick) count <= '0;
            else                       count <= count + CW'(1);
        end
    end

`ifdef BRAKE_EN
    logic brake_l;
    logic brake_r;
    logic in_left;
    logic in_right;

    assign in_left  = (state == L1) || (state == L2) || (state == L3) || (state == LOFF);
    assign in_right = (state == R1) || (state == R2) || (state == R3) || (state == ROFF);

    // Brake lights the bank not used by the current sweep; both banks when idle; reset keeps all dark.
    assign brake_l = brake & ~reset & ((state == IDLE) | in_right);
    assign brake_r = brake & ~reset & ((state == IDLE) | in_left);

    assign LA = lamp_q[5] | brake_l;
    assign LB = lamp_q[4] | brake_l;
    assign LC = lamp_q[3] | brake_l;
    assign RA = lamp_q[2] | brake_r;
    assign RB = lamp_q[1] | brake_r;
    assign RC = lamp_q[0] | brake_r;
`else
    assign LA = lamp_q[5];
    assign LB = lamp_q[4];
    assign LC = lamp_q[3];
    assign RA = lamp_q[2];
    assign RB = lamp_q[1];
    assign RC = lamp_q[0];
`endif

    assign active = active_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed scoreboard bench for tail_light_sequencer with a short prescaler.
module tb_tail_light_sequencer;

    localparam int unsigned TICK_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    logic left;
    logic right;
    logic hazard;
`ifdef BRAKE_EN
    logic brake;
`endif
    logic LA, LB, LC, RA, RB, RC, active;

    tail_light_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
`ifdef BRAKE_EN
        .brake  (brake),
`endif
        .LA     (LA),
        .LB     (LB),
        .LC     (LC),
        .RA     (RA),
        .RB     (RB),
        .RC     (RC),
        .active (active)
    );

    always #5 clk = ~clk;

    // Expected {LA,LB,LC,RA,RB,RC,active}
    localparam logic [6:0] OFF   = 7'b0000000;
    localparam logic [6:0] L1V   = 7'b1000001;
    localparam logic [6:0] L2V   = 7'b1100001;
    localparam logic [6:0] L3V   = 7'b1110001;
    localparam logic [6:0] LOFFV = 7'b0000001;
    localparam logic [6:0] R1V   = 7'b0001001;
    localparam logic [6:0] R2V   = 7'b0001101;
    localparam logic [6:0] R3V   = 7'b0001111;
    localparam logic [6:0] ROFFV = 7'b0000001;
    localparam logic [6:0] HONV  = 7'b1111111;
    localparam logic [6:0] HOFFV = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [6:0] obs();
        return {LA, LB, LC, RA, RB, RC, active};
    endfunction

    task automatic push(input string tag, input logic [6:0] v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.exp = v;
            sb.push_back(e);
        end
    endtask

    task automatic check_one();
        exp_t       e;
        logic [6:0] o;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%0d expected>0", sb.size());
        end else begin
            e = sb.pop_front();
            o = obs();
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b t=%0t", e.tag, o, e.exp, $time);
            end
        end
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            check_one();
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b1;
        left   = 1'b1;
        right  = 1'b0;
        hazard = 1'b0;
`ifdef BRAKE_EN
        brake  = 1'b0;
`endif
        @(negedge clk);
        push("reset_dark", OFF, 1);
        check_one();
        reset = 1'b0;
        @(negedge clk);

        // Left sweep, 4 clk per step, repeating every 16 clk
        push("left_l1", L1V, 4);
        push("left_l2", L2V, 4);
        push("left_l3", L3V, 4);
        push("left_off", LOFFV, 4);
        push("left_l1_again", L1V, 4);
        drain(20);

        // Direction change in L2 waits for LOFF, then right starts
        left  = 1'b0;
        right = 1'b1;
        push("chg_l2", L2V, 4);
        push("chg_l3", L3V, 4);
        push("chg_loff", LOFFV, 4);
        push("chg_r1", R1V, 4);
        push("chg_r2", R2V, 1);
        drain(17);

        // Release mid-sequence: right completes through ROFF then IDLE
        right = 1'b0;
        push("rel_r2", R2V, 3);
        push("rel_r3", R3V, 4);
        push("rel_roff", ROFFV, 4);
        push("rel_idle", OFF, 1);
        drain(12);

        // left&right acts as hazard
        left  = 1'b1;
        right = 1'b1;
        push("haz_idle", OFF, 1);
        push("haz_on", HONV, 4);
        push("haz_off", HOFFV, 4);
        push("haz_on2", HONV, 2);
        drain(11);
        left  = 1'b0;
        right = 1'b0;
        push("haz_on2_tail", HONV, 2);
        push("haz_off_last", HOFFV, 4);
        push("haz_idle_end", OFF, 2);
        drain(8);

        // Hazard pre-empts left at the next tick, skipping L2
        left = 1'b1;
        push("pre_idle", OFF, 1);
        push("pre_l1", L1V, 2);
        drain(3);
        hazard = 1'b1;
        push("pre_l1_tail", L1V, 2);
        push("pre_hon", HONV, 2);
        drain(4);

        // Asynchronous reset mid-step
        reset = 1'b1;
        #1;
        push("async_reset", OFF, 1);
        check_one();
        hazard = 1'b0;
        left   = 1'b0;
        @(negedge clk);
        push("reset_held", OFF, 1);
        check_one();
        reset = 1'b0;
        @(negedge clk);
        push("post_reset_idle", OFF, 1);
        check_one();

`ifdef BRAKE_EN
        brake = 1'b1;
        #1;
        push("brake_idle", 7'b1111110, 1);
        check_one();
        left = 1'b1;
        @(negedge clk);
        push("brake_l1", 7'b1001111, 4);
        push("brake_l2", 7'b1101111, 1);
        drain(5);
        brake = 1'b0;
        left  = 1'b0;
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
